// File: rtl/spi_slave.sv
// SPI slave feeding a RAM command interface: 10-bit command/payload frames in, read data out.
// Optional frame-error pulse output enabled with `define SPI_SLAVE_FRAME_ERR_EN.
module spi_slave #(
    parameter int unsigned TX_WIDTH = 8,
    parameter int unsigned RX_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic [RX_WIDTH-1:0] rx_data,
    output logic                rx_valid,
    input  logic [TX_WIDTH-1:0] tx_data,
    input  logic                tx_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic                frame_err
`endif
);

    localparam int unsigned TxCntW = $clog2(TX_WIDTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StChkCmd,
        StWrite,
        StReadAdd,
        StReadData
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [RX_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [RX_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_done_q, rx_done_d;
    logic                rd_addr_flag_q, rd_addr_flag_d;
    logic [TX_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [TxCntW-1:0]   tx_cnt_q, tx_cnt_d;
    logic                tx_busy_q, tx_busy_d;
    logic                tx_done_q, tx_done_d;
    logic                miso_q, miso_d;
    logic                frame_err_q, frame_err_d;
    logic                in_frame;

    assign in_frame = (state_q == StWrite) || (state_q == StReadAdd) || (state_q == StReadData);

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_done_d      = rx_done_q;
        rd_addr_flag_d = rd_addr_flag_q;
        tx_shift_d     = tx_shift_q;
        tx_cnt_d       = tx_cnt_q;
        tx_busy_d      = tx_busy_q;
        tx_done_d      = tx_done_q;
        miso_d         = 1'b0;
        frame_err_d    = 1'b0;

        if (SS_n) begin
            // Abort: drop partial frame and any in-flight read data; flag is kept.
            state_d     = StIdle;
            bit_cnt_d   = '0;
            rx_shift_d  = '0;
            rx_done_d   = 1'b0;
            tx_shift_d  = '0;
            tx_cnt_d    = '0;
            tx_busy_d   = 1'b0;
            tx_done_d   = 1'b0;
            frame_err_d = in_frame && (!rx_done_q || tx_busy_q);
        end else begin
            case (state_q)
                StIdle:   state_d = StChkCmd;
                StChkCmd: begin
                    if (!MOSI)               state_d = StWrite;
                    else if (rd_addr_flag_q) state_d = StReadData;
                    else                     state_d = StReadAdd;
                end
                default: begin
                    if (!rx_done_q) begin
                        rx_shift_d = {rx_shift_q[RX_WIDTH-2:0], MOSI};
                        if (bit_cnt_q == 4'(RX_WIDTH - 1)) begin
                            rx_data_d  = rx_shift_d;
                            rx_valid_d = 1'b1;
                            rx_done_d  = 1'b1;
                            bit_cnt_d  = '0;
                            if (state_q == StReadAdd)  rd_addr_flag_d = 1'b1;
                            if (state_q == StReadData) rd_addr_flag_d = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end

                    if (state_q == StReadData && rx_done_q && !tx_busy_q && !tx_done_q
                        && tx_valid) begin
                        miso_d     = tx_data[TX_WIDTH-1];
                        tx_shift_d = tx_data << 1;
                        tx_cnt_d   = TxCntW'(TX_WIDTH - 1);
                        tx_busy_d  = 1'b1;
                    end else if (tx_busy_q) begin
                        if (tx_cnt_q != '0) begin
                            miso_d     = tx_shift_q[TX_WIDTH-1];
                            tx_shift_d = tx_shift_q << 1;
                            tx_cnt_d   = tx_cnt_q - 1'b1;
                        end else begin
                            tx_busy_d = 1'b0;
                            tx_done_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_done_q      <= 1'b0;
            rd_addr_flag_q <= 1'b0;
            tx_shift_q     <= '0;
            tx_cnt_q       <= '0;
            tx_busy_q      <= 1'b0;
            tx_done_q      <= 1'b0;
            miso_q         <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_done_q      <= rx_done_d;
            rd_addr_flag_q <= rd_addr_flag_d;
            tx_shift_q     <= tx_shift_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_busy_q      <= tx_busy_d;
            tx_done_q      <= tx_done_d;
            miso_q         <= miso_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`else
    logic unused_frame_err;
    assign unused_frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave: write, read, abort and async-reset sequences.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic       frame_err;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    int   rx_pulses = 0;
    int   exp_pulses = 0;
    logic miso_mon_en = 1'b0;
    logic miso_seen = 1'b0;
    logic [7:0] exp_bits;

    always #5 clk = ~clk;

    spi_slave #(
        .TX_WIDTH(8),
        .RX_WIDTH(10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always @(posedge clk) begin
        if (rx_valid) rx_pulses <= rx_pulses + 1;
        if (miso_mon_en && MISO) miso_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ss, input logic mosi);
        @(negedge clk);
        SS_n = ss;
        MOSI = mosi;
    endtask

    // Leaves the bench at the negedge where rx_valid of this frame is visible.
    task automatic send_frame(input logic sel, input logic [9:0] word);
        drive(1'b0, 1'b0);
        drive(1'b0, sel);
        for (int i = 9; i >= 0; i--) drive(1'b0, word[i]);
        drive(1'b0, 1'b0);
    endtask

    task automatic end_frame();
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        #12;
        check("rst_miso", MISO, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_state", dut.state_q, 0);
        check("rst_flag", dut.rd_addr_flag_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0);

        // Write address with tx_valid held high: it must be ignored.
        tx_valid = 1'b1; tx_data = 8'hFF; miso_mon_en = 1'b1;
        send_frame(1'b0, 10'h0A5);
        check("wa_rx_valid", rx_valid, 1);
        check("wa_rx_data", rx_data, 10'h0A5);
        drive(1'b0, 1'b1);
        check("wa_strobe_1cyc", rx_valid, 0);
        drive(1'b0, 1'b0);
        end_frame();
        exp_pulses++;
        check("wa_pulses", rx_pulses, exp_pulses);
        check("wa_hold", rx_data, 10'h0A5);

        send_frame(1'b0, 10'h13C);
        check("wd_rx_valid", rx_valid, 1);
        check("wd_rx_data", rx_data, 10'h13C);
        end_frame();
        exp_pulses++;
        check("wd_pulses", rx_pulses, exp_pulses);
        tx_valid = 1'b0; miso_mon_en = 1'b0;
        check("write_miso_quiet", miso_seen, 0);

        // Read address frame sets the flag.
        send_frame(1'b1, 10'h207);
        check("ra_rx_data", rx_data, 10'h207);
        check("ra_flag_set", dut.rd_addr_flag_q, 1);
        end_frame();
        exp_pulses++;

        // Abort a READ_DATA frame after 5 bits: no strobe, flag untouched.
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        check("abort_state", dut.state_q, 0);
        check("abort_miso", MISO, 0);
        check("abort_flag_kept", dut.rd_addr_flag_q, 1);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("abort_frame_err", frame_err, 1);
`endif
        drive(1'b1, 1'b0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("abort_frame_err_1cyc", frame_err, 0);
`endif
        check("abort_no_pulse", rx_pulses, exp_pulses);
        check("abort_rx_hold", rx_data, 10'h207);

        // Read data frame, then tx_valid in the strobe cycle.
        send_frame(1'b1, 10'h300);
        check("rd_rx_valid", rx_valid, 1);
        check("rd_rx_data", rx_data, 10'h300);
        check("rd_flag_clr", dut.rd_addr_flag_q, 0);
        check("rd_miso_idle", MISO, 0);
        tx_valid = 1'b1; tx_data = 8'hC3;
        exp_bits = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            drive(1'b0, 1'b1);
            tx_valid = 1'b0; tx_data = 8'h00;
            check($sformatf("rd_miso_bit%0d", i), MISO, exp_bits[i]);
        end
        drive(1'b0, 1'b0);
        check("rd_miso_after", MISO, 0);
        tx_valid = 1'b1; tx_data = 8'hFF;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        tx_valid = 1'b0;
        check("rd_second_txv_ignored", MISO, 0);
        end_frame();
        exp_pulses++;
        check("rd_pulses", rx_pulses, exp_pulses);

        // Async reset in the middle of the MISO shift.
        send_frame(1'b1, 10'h2AB);
        end_frame();
        send_frame(1'b1, 10'h3FF);
        tx_valid = 1'b1; tx_data = 8'h80;
        drive(1'b0, 1'b0);
        tx_valid = 1'b0;
        check("rs_miso_pre", MISO, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_miso_async", MISO, 0);
        check("rs_state_async", dut.state_q, 0);
        check("rs_flag_async", dut.rd_addr_flag_q, 0);
        check("rs_rx_data_async", rx_data, 0);
        SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0);

        send_frame(1'b0, 10'h155);
        check("post_rst_rx_valid", rx_valid, 1);
        check("post_rst_rx_data", rx_data, 10'h155);
        end_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: TX_WIDTH, default 8; width of the read-data word shifted out on MISO.
REQ-002 Parameter: RX_WIDTH, default 10; width of the parallel word delivered per frame; fixed at 10 for the RAM command format.
REQ-003 Port: clk  input  1  single system clock, also the serial bit clock; all logic on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: SS_n  input  1  slave select, active-low; frame boundary.
REQ-006 Port: MOSI  input  1  serial data in, MSB first.
REQ-007 Port: MISO  output  1  serial data out, MSB first.
REQ-008 Port: rx_data  output  RX_WIDTH  assembled word {cmd[1:0], payload[7:0]} to downstream RAM.
REQ-009 Port: rx_valid  output  1  one-cycle strobe; rx_data valid.
REQ-010 Port: tx_data  input  TX_WIDTH  read data from RAM.
REQ-011 Port: tx_valid  input  1  tx_data valid strobe from RAM.
REQ-012 Port: frame_err  output  1  present only with SPI_SLAVE_FRAME_ERR_EN (see REQ-032).

Function
REQ-013 FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-014 IDLE -> CHK_CMD on the first cycle SS_n is sampled 0; otherwise stays in IDLE.
REQ-015 CHK_CMD samples the MOSI selector bit (not stored): 0 -> WRITE; 1 with rd_addr_flag=0 -> READ_ADD; 1 with rd_addr_flag=1 -> READ_DATA.
REQ-016 WRITE/READ_ADD/READ_DATA shift MOSI into the RX shift register on RX_WIDTH consecutive cycles, MSB first, with a 4-bit bit counter.
REQ-017 Cycle after the 10th bit is sampled: rx_data <= shift register, rx_valid = 1 for exactly one cycle.
REQ-018 rx_data holds its value until the next completed frame.
REQ-019 READ_ADD: rd_addr_flag set to 1 with the rx_valid strobe.
REQ-020 READ_DATA: rd_addr_flag cleared with the rx_valid strobe; the FSM then waits indefinitely for tx_valid=1.
REQ-021 On tx_valid=1 in READ_DATA after rx_valid: capture tx_data; drive MISO with bits TX_WIDTH-1..0 on the next TX_WIDTH cycles, one bit per cycle.
REQ-022 MISO = 0 in every cycle not covered by REQ-021.
REQ-023 tx_valid while not waiting per REQ-020 is ignored.
REQ-024 After the frame completes, further MOSI bits are ignored; the FSM holds until SS_n = 1.
REQ-025 SS_n = 1 in any state -> IDLE next cycle.
REQ-026 On SS_n = 1 abort: partial shift data discarded, no rx_valid, bit counter cleared, MISO forced 0.
REQ-027 rd_addr_flag is unchanged by an abort.
REQ-028 rx_valid and tx_valid in the same cycle: each is handled independently; no interaction.

Reset
REQ-029 rst_n = 0 forces asynchronously: state = IDLE, MISO = 0, rx_data = 0, rx_valid = 0, rd_addr_flag = 0, counters = 0, TX/RX shift registers = 0, frame_err = 0.
REQ-030 Reset asserted mid-frame: frame lost, no rx_valid; operation resumes at the first SS_n falling edge after release.

Configuration
REQ-031 Macro SPI_SLAVE_FRAME_ERR_EN selects the frame-error output.
REQ-032 Defined: port frame_err exists; it pulses 1 for one cycle when SS_n rises in WRITE/READ_ADD/READ_DATA before 10 bits are received, or during the MISO shift.
REQ-033 Undefined: port frame_err and its logic are absent; all other behaviour is identical.

Verification
REQ-034 Write address: SS_n=0, MOSI 0 then 00_1010_0101, SS_n=1 -> single rx_valid pulse, rx_data=10'h0A5, MISO stays 0.
REQ-035 Write data: selector 0, then 01_0011_1100 -> rx_data=10'h13C, one rx_valid pulse.
REQ-036 Read sequence: selector 1 + 10_0000_0111 -> rx_data=10'h207, flag=1; next frame selector 1 + 11_0000_0000 -> rx_data=10'h300; tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 over the next 8 cycles, flag=0.
REQ-037 Abort: SS_n raised after 5 bits -> no rx_valid, state IDLE next cycle; frame_err=1 for one cycle when the macro is defined.
REQ-038 Async reset asserted mid-MISO shift -> MISO=0 and state IDLE immediately without a clock edge; flag=0.
